// File: rtl/can_wb_tx_sequencer_if.sv
// can_wb_tx_sequencer_if
// Bundles the request handshake, job status, host Wishbone pass-through and
// the CAN core register-port Wishbone master signals of can_wb_tx_sequencer.
//   slave  : view taken by the sequencer (requests in, core port out)
//   master : view taken by the surrounding logic (requester, host, core)
// Signal names keep their original _i/_o suffixes relative to the sequencer.
interface can_wb_tx_sequencer_if;
  // frame request handshake and job status
  logic        req_valid_i;
  logic        req_ready_o;
  logic [10:0] req_id_i;
  logic        req_rtr_i;
  logic [3:0]  req_dlc_i;
  logic [63:0] req_data_i;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  // host Wishbone pass-through
  logic        host_cyc_i;
  logic        host_stb_i;
  logic        host_we_i;
  logic [7:0]  host_adr_i;
  logic [7:0]  host_dat_i;
  logic [7:0]  host_dat_o;
  logic        host_ack_o;
  // CAN core register port
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;

  modport slave (
    input  req_valid_i, req_id_i, req_rtr_i, req_dlc_i, req_data_i,
    output req_ready_o, done_o, err_o, busy_o,
    input  host_cyc_i, host_stb_i, host_we_i, host_adr_i, host_dat_i,
    output host_dat_o, host_ack_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport master (
    output req_valid_i, req_id_i, req_rtr_i, req_dlc_i, req_data_i,
    input  req_ready_o, done_o, err_o, busy_o,
    output host_cyc_i, host_stb_i, host_we_i, host_adr_i, host_dat_i,
    input  host_dat_o, host_ack_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/can_wb_tx_sequencer.sv
// can_wb_tx_sequencer
// Loads a BasicCAN TX frame into the CAN core over its 8-bit Wishbone register
// port, issues the TX request command and polls status until the frame is
// sent. A 2-way round-robin arbiter shares the core port with a host port.
// Ports:
//   wb_clk_i : clock for all logic
//   wb_rst_i : asynchronous active-high reset
//   bus      : request handshake, done/err/busy, host pass-through and core
//              register port (see can_wb_tx_sequencer_if)
module can_wb_tx_sequencer #(
  parameter logic [7:0]  TXB_BASE    = 8'd10,
  parameter logic [7:0]  CMD_ADDR    = 8'd1,
  parameter logic [7:0]  STAT_ADDR   = 8'd2,
  parameter int unsigned POLL_LIMIT  = 1024,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  can_wb_tx_sequencer_if.slave  bus
);

  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK_TBS, S_WR_ID1, S_WR_ID2, S_WR_DATA,
    S_WR_CMD, S_POLL_TCS, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {G_NONE, G_HOST, G_SEQ} gnt_e;

  state_e      state_q, state_d;
  gnt_e        gnt_q, gnt_d;
  logic        last_host_q, last_host_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  data_cnt_q, data_cnt_d;
  logic [10:0] id_q, id_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [63:0] data_q, data_d;
  logic        seq_req_q, seq_req_d;
  logic        seq_we_q, seq_we_d;
  logic [7:0]  seq_adr_q, seq_adr_d;
  logic [7:0]  seq_dat_q, seq_dat_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        host_req;
  logic        seq_ack;
  logic        seq_tmo;
  logic [2:0]  nxt_idx;
  logic        data_last;

  assign host_req = bus.host_cyc_i & bus.host_stb_i;
  assign seq_ack  = (gnt_q == G_SEQ) & bus.wb_ack_i;
  assign seq_tmo  = (gnt_q == G_SEQ) & ~bus.wb_ack_i & (tmo_q == TMO_LAST);

  // Grant is registered: the cycle after an access ends is spent in G_NONE
  // with the port idle, which doubles as the mandatory idle cycle and the
  // arbitration slot for the next access.
  always_comb begin
    gnt_d       = gnt_q;
    last_host_d = last_host_q;
    unique case (gnt_q)
      G_NONE: begin
        if (host_req && (!seq_req_q || !last_host_q)) begin
          gnt_d       = G_HOST;
          last_host_d = 1'b1;
        end else if (seq_req_q) begin
          gnt_d       = G_SEQ;
          last_host_d = 1'b0;
        end
      end
      G_HOST:  if (!bus.host_cyc_i || bus.wb_ack_i) gnt_d = G_NONE;
      G_SEQ:   if (bus.wb_ack_i || seq_tmo) gnt_d = G_NONE;
      default: gnt_d = G_NONE;
    endcase
    tmo_d = (gnt_q == G_SEQ && !bus.wb_ack_i && !seq_tmo) ? tmo_q + 1'b1 : '0;
  end

  always_comb begin
    bus.wb_cyc_o   = 1'b0;
    bus.wb_stb_o   = 1'b0;
    bus.wb_we_o    = 1'b0;
    bus.wb_adr_o   = '0;
    bus.wb_dat_o   = '0;
    bus.host_ack_o = 1'b0;
    bus.host_dat_o = '0;
    unique case (gnt_q)
      G_HOST: begin
        bus.wb_cyc_o   = bus.host_cyc_i;
        bus.wb_stb_o   = bus.host_stb_i;
        bus.wb_we_o    = bus.host_we_i;
        bus.wb_adr_o   = bus.host_adr_i;
        bus.wb_dat_o   = bus.host_dat_i;
        bus.host_ack_o = bus.wb_ack_i;
        bus.host_dat_o = bus.wb_dat_i;
      end
      G_SEQ: begin
        bus.wb_cyc_o = 1'b1;
        bus.wb_stb_o = 1'b1;
        bus.wb_we_o  = seq_we_q;
        bus.wb_adr_o = seq_adr_q;
        bus.wb_dat_o = seq_dat_q;
      end
      default: ;
    endcase
  end

  // On each acked access the next access is loaded straight away; the
  // arbiter keeps it off the port until it is granted again.
  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    byte_idx_d = byte_idx_q;
    data_cnt_d = data_cnt_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    seq_req_d  = seq_req_q;
    seq_we_d   = seq_we_q;
    seq_adr_d  = seq_adr_q;
    seq_dat_d  = seq_dat_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    nxt_idx    = (state_q == S_WR_ID2) ? 3'd0 : byte_idx_q + 3'd1;
    data_last  = (state_q == S_WR_ID2) ? (data_cnt_q == 4'd0)
                                       : ({1'b0, byte_idx_q} == data_cnt_q - 4'd1);
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i && ready_q) begin
          id_d       = bus.req_id_i;
          rtr_d      = bus.req_rtr_i;
          dlc_d      = bus.req_dlc_i;
          data_d     = bus.req_data_i;
          data_cnt_d = bus.req_rtr_i ? 4'd0
                     : ((bus.req_dlc_i > 4'd8) ? 4'd8 : bus.req_dlc_i);
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          poll_d     = '0;
          seq_req_d  = 1'b1;
          seq_we_d   = 1'b0;
          seq_adr_d  = STAT_ADDR;
          seq_dat_d  = '0;
          state_d    = S_CHK_TBS;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        if (seq_tmo) begin
          seq_req_d = 1'b0;
          state_d   = S_ERR;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else if (seq_ack) begin
          unique case (state_q)
            S_CHK_TBS: begin
              if (bus.wb_dat_i[2]) begin
                state_d   = S_WR_ID1;
                seq_we_d  = 1'b1;
                seq_adr_d = TXB_BASE;
                seq_dat_d = id_q[10:3];
              end else if (poll_q == POLL_LAST) begin
                seq_req_d = 1'b0;
                state_d   = S_ERR;
                done_d    = 1'b1;
                err_d     = 1'b1;
              end else begin
                poll_d = poll_q + 1'b1;
              end
            end
            S_WR_ID1: begin
              state_d   = S_WR_ID2;
              seq_adr_d = TXB_BASE + 8'd1;
              seq_dat_d = {id_q[2:0], rtr_q, dlc_q};
            end
            S_WR_ID2, S_WR_DATA: begin
              if (data_last) begin
                state_d   = S_WR_CMD;
                seq_adr_d = CMD_ADDR;
                seq_dat_d = 8'h01;
              end else begin
                state_d    = S_WR_DATA;
                byte_idx_d = nxt_idx;
                seq_adr_d  = TXB_BASE + 8'd2 + {5'b0, nxt_idx};
                seq_dat_d  = data_q[{nxt_idx, 3'b000} +: 8];
              end
            end
            S_WR_CMD: begin
              state_d   = S_POLL_TCS;
              seq_we_d  = 1'b0;
              seq_adr_d = STAT_ADDR;
              seq_dat_d = '0;
              poll_d    = '0;
            end
            S_POLL_TCS: begin
              if (bus.wb_dat_i[3]) begin
                seq_req_d = 1'b0;
                state_d   = S_DONE;
                done_d    = 1'b1;
              end else if (poll_q == POLL_LAST) begin
                seq_req_d = 1'b0;
                state_d   = S_ERR;
                done_d    = 1'b1;
                err_d     = 1'b1;
              end else begin
                poll_d = poll_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= G_NONE;
      last_host_q <= 1'b1;
      tmo_q       <= '0;
      poll_q      <= '0;
      byte_idx_q  <= '0;
      data_cnt_q  <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      seq_req_q   <= 1'b0;
      seq_we_q    <= 1'b0;
      seq_adr_q   <= '0;
      seq_dat_q   <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_host_q <= last_host_d;
      tmo_q       <= tmo_d;
      poll_q      <= poll_d;
      byte_idx_q  <= byte_idx_d;
      data_cnt_q  <= data_cnt_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      seq_req_q   <= seq_req_d;
      seq_we_q    <= seq_we_d;
      seq_adr_q   <= seq_adr_d;
      seq_dat_q   <= seq_dat_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule
